// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives the PC register and a single-outstanding imem port,
// and hands fetched instructions to IF/ID, squashing them on redirect.
module pc_fetch_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  output logic                  pc_write,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall_i,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INSTR_BYTES);

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;

  logic                  pc_write_c;
  logic [ADDR_WIDTH-1:0] pc_next_c;
  logic                  req_c;

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    pc_write_c = 1'b0;
    pc_next_c  = pc_cur;
    req_c      = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        pc_write_c = 1'b1;
        pc_next_c  = RESET_VECTOR;
        state_d    = S_REQ;
      end
      S_REQ: begin
        req_c = 1'b1;
        if (imem_gnt) begin
          req_pc_d   = pc_cur;
          pc_write_c = 1'b1;
          pc_next_c  = pc_cur + INC;
          kill_d     = redirect_valid;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          if (!kill_q && !redirect_valid) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = req_pc_q;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || !stall_i) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
    // RESET_VECTOR must win over any redirect seen while booting
    if (redirect_valid && state_q != S_BOOT) begin
      pc_write_c = 1'b1;
      pc_next_c  = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      kill_q     <= 1'b0;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign pc_write  = rst_n & pc_write_c;
  assign pc_next   = pc_next_c;
  assign imem_req  = rst_n & req_c;
  assign imem_addr = pc_cur;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios, then random traffic
// scored against the program-order PC stream and a memory content function.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h100),
    .INSTR_BYTES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .pc_write       (pc_write),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // Program_Counter register the controller drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_cur <= '0;
    else if (pc_write) pc_cur <= pc_next;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                     input logic st, input logic rdr, input logic [31:0] tg);
    imem_gnt        = g;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    stall_i         = st;
    redirect_valid  = rdr;
    redirect_target = tg;
    #1;
  endtask

  logic [31:0] exp_pc, out_addr, tgt;
  logic        outst, st, rdr;
  int          lat, since, deliv;

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pc_write", {31'b0, pc_write}, 0);
    chk("rst_imem_req", {31'b0, imem_req}, 0);
    chk("rst_if_valid", {31'b0, if_valid}, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    chk("boot_pc_write", {31'b0, pc_write}, 1);
    chk("boot_pc_next", pc_next, 32'h100);
    chk("boot_req", {31'b0, imem_req}, 0);
    cyc();
    drv(1, 0, 0, 0, 0, 0);
    chk("f0_req", {31'b0, imem_req}, 1);
    chk("f0_addr", imem_addr, 32'h100);
    chk("f0_pc_write", {31'b0, pc_write}, 1);
    chk("f0_pc_next", pc_next, 32'h104);
    cyc();
    drv(0, 1, 32'hD000_0000, 0, 0, 0);
    chk("f0_wait_req", {31'b0, imem_req}, 0);
    chk("f0_wait_pcw", {31'b0, pc_write}, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    chk("f0_valid", {31'b0, if_valid}, 1);
    chk("f0_if_pc", if_pc, 32'h100);
    chk("f0_if_instr", if_instr, 32'hD000_0000);
    cyc();
    drv(1, 0, 0, 0, 0, 0);
    chk("f1_addr", imem_addr, 32'h104);
    cyc();
    drv(0, 1, 32'hD000_0001, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drv(0, 0, 0, 1, 0, 0);
      chk("hold_valid", {31'b0, if_valid}, 1);
      chk("hold_if_pc", if_pc, 32'h104);
      chk("hold_if_instr", if_instr, 32'hD000_0001);
      chk("hold_no_req", {31'b0, imem_req}, 0);
    end
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    chk("hold_end_valid", {31'b0, if_valid}, 1);
    chk("hold_end_pc", if_pc, 32'h104);
    cyc();
    drv(1, 0, 0, 0, 0, 0);
    chk("f2_addr", imem_addr, 32'h108);
    cyc();
    drv(0, 1, 32'hD000_0002, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    chk("f2_if_pc", if_pc, 32'h108);
    chk("f2_if_instr", if_instr, 32'hD000_0002);
    for (int i = 0; i < 5; i++) begin
      cyc();
      drv(0, 0, 0, 0, 0, 0);
      chk("nognt_req", {31'b0, imem_req}, 1);
      chk("nognt_addr", imem_addr, 32'h10C);
      chk("nognt_pcw", {31'b0, pc_write}, 0);
    end
    cyc();
    drv(1, 0, 0, 0, 0, 0);
    chk("f3_pc_next", pc_next, 32'h110);
    cyc();
    drv(0, 0, 0, 0, 1, 32'h2000);
    chk("rdw_pcw", {31'b0, pc_write}, 1);
    chk("rdw_pc_next", pc_next, 32'h2000);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    cyc();
    drv(0, 1, 32'hBAD0_0001, 0, 0, 0);
    cyc();
    drv(1, 0, 0, 0, 1, 32'h3000);
    chk("rdw_dropped", {31'b0, if_valid}, 0);
    chk("rdw_addr", imem_addr, 32'h2000);
    chk("rdg_pc_next", pc_next, 32'h3000);
    chk("rdg_pcw", {31'b0, pc_write}, 1);
    cyc();
    drv(0, 1, 32'hBAD0_0002, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("rdg_dropped", {31'b0, if_valid}, 0);
    chk("rdg_addr", imem_addr, 32'h3000);
    cyc();
    drv(1, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0);
    cyc();
    drv(0, 1, 32'hD000_0003, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    cyc();
    drv(1, 0, 0, 0, 0, 0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 0);
    chk("arst_req", {31'b0, imem_req}, 0);
    chk("arst_pcw", {31'b0, pc_write}, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    drv(0, 1, 32'hBAD0_0003, 0, 1, 32'h5000);
    chk("boot_rd_pcw", {31'b0, pc_write}, 1);
    chk("boot_rd_next", pc_next, 32'h100);
    cyc();
    drv(0, 1, 32'hBAD0_0004, 0, 0, 0);
    chk("stray_req", {31'b0, imem_req}, 1);
    chk("stray_addr", imem_addr, 32'h100);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    chk("stray_valid", {31'b0, if_valid}, 0);
    chk("stray_req2", {31'b0, imem_req}, 1);

    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n  = 1'b1;
    exp_pc = 32'h100;
    outst  = 1'b0;
    since  = 0;
    deliv  = 0;
    lat    = 0;
    out_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      drv(0, 0, 0, 0, 0, 0);
      if (outst) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(out_addr);
          outst       = 1'b0;
        end else begin
          lat--;
        end
      end
      st  = ($urandom_range(0, 2) == 0);
      rdr = (since >= 2) && ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom() & ~32'h3);
      stall_i         = st;
      redirect_valid  = rdr;
      redirect_target = tgt;
      imem_gnt        = ($urandom_range(0, 1) == 1);
      #1;
      if (imem_req) begin
        chk("r_addr", imem_addr, pc_cur);
        chk("r_one_outst", {31'b0, outst}, 0);
      end
      if (rdr) begin
        chk("r_rd_pcw", {31'b0, pc_write}, 1);
        chk("r_rd_next", pc_next, tgt);
      end else if (imem_req && imem_gnt) begin
        chk("r_inc_pcw", {31'b0, pc_write}, 1);
        chk("r_inc_next", pc_next, pc_cur + 32'd4);
      end
      if (if_valid && !st && !rdr) begin
        chk("r_if_pc", if_pc, exp_pc);
        chk("r_if_instr", if_instr, memf(if_pc));
        exp_pc = exp_pc + 32'd4;
        deliv++;
      end
      if (rdr) exp_pc = tgt;
      if (imem_req && imem_gnt) begin
        outst    = 1'b1;
        out_addr = imem_addr;
        lat      = $urandom_range(0, 2);
      end
      since++;
      cyc();
    end
    chk("r_progress", {31'b0, deliv > 100}, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
